// File: rtl/debug_link_pkg.sv
// Shared definitions for the host-side debug link receiver: frame geometry,
// lock FSM encoding and the bit positions of the tag's status word.
package debug_link_pkg;

    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned SYNC_LEN  = 4;
    localparam int unsigned SYNC_BASE = 12;
    localparam int unsigned STATUS_W  = SYNC_BASE;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } link_state_e;

    localparam int unsigned DBG_PACKET_COMPLETE = 0;
    localparam int unsigned DBG_CMD_COMPLETE    = 1;
    localparam int unsigned DBG_HANDLEMATCH     = 2;
    localparam int unsigned DBG_DOCRC           = 3;
    localparam int unsigned DBG_RX_EN           = 4;
    localparam int unsigned DBG_TX_EN           = 5;
    localparam int unsigned DBG_BITOUT          = 6;
    localparam int unsigned DBG_BITCLK          = 7;
    localparam int unsigned DBG_RNGBITIN        = 8;
    localparam int unsigned DBG_RX_OVERFLOW     = 9;
    localparam int unsigned DBG_TX_DONE         = 10;
    localparam int unsigned DBG_TXSETUPDONE     = 11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/debug_frame_reader_if.sv
// Stream input and status outputs of the debug frame reader; the reader
// itself takes the master side.
interface debug_frame_reader_if;
    import debug_link_pkg::*;

    logic                debug_in;
    logic                enable;
    logic [STATUS_W-1:0] snapshot;
    logic                frame_valid;
    logic                locked;
    logic                sync_lost;
    logic [15:0]         frame_count;
    logic [7:0]          err_count;

    modport master (
        input  debug_in, enable,
        output snapshot, frame_valid, locked, sync_lost, frame_count, err_count
    );

    modport slave (
        output debug_in, enable,
        input  snapshot, frame_valid, locked, sync_lost, frame_count, err_count
    );

endinterface

// File: rtl/debug_sync_check.sv
// Serial-to-parallel window over the debug stream: newest bit at the top,
// plus a combinational match of the latest four samples against the sync tail.
module debug_sync_check
    import debug_link_pkg::*;
#(
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1010
) (
    input  logic                debug_clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                bit_i,
    output logic                window_match_o,
    output logic [STATUS_W-1:0] frame_word_o
);

    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [FRAME_LEN-1:0] word_now;

    // Includes the bit being sampled this cycle, so at slot 15 word_now holds
    // the whole frame with slot i at bit i.
    always_comb begin
        word_now       = {bit_i, shift_q[FRAME_LEN-1:1]};
        window_match_o = (word_now[SYNC_BASE +: SYNC_LEN] == SYNC_WORD);
        frame_word_o   = word_now[STATUS_W-1:0];
        shift_d        = enable_i ? word_now : '0;
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/debug_frame_reader.sv
// Host-side deserializer for the tag's 16-slot debug frames: hunts for the sync
// tail, confirms it over one full frame, then tracks lock and snapshots status.
module debug_frame_reader
    import debug_link_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 16,
    parameter logic [3:0]  SYNC_WORD = 4'b1010,
    parameter int unsigned MAX_MISS  = 3
) (
    input  logic                 debug_clk,
    input  logic                 reset,
    debug_frame_reader_if.master bus
);

    localparam int unsigned       SLOT_W    = $clog2(FRAME_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
    localparam logic [2:0]        MISS_LAST = 3'(MAX_MISS - 1);

    link_state_e         state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [2:0]          miss_q, miss_d;
    logic [STATUS_W-1:0] snapshot_q, snapshot_d;
    logic                frame_valid_q, frame_valid_d;
    logic                locked_q, locked_d;
    logic                sync_lost_q, sync_lost_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                window_match;
    logic [STATUS_W-1:0] frame_word;
    logic                slot_end;
    logic                emit;

    debug_sync_check #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_check (
        .debug_clk      (debug_clk),
        .reset          (reset),
        .enable_i       (bus.enable),
        .bit_i          (bus.debug_in),
        .window_match_o (window_match),
        .frame_word_o   (frame_word)
    );

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q + SLOT_W'(1);
        miss_d        = miss_q;
        snapshot_d    = snapshot_q;
        frame_valid_d = 1'b0;
        sync_lost_d   = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        emit          = 1'b0;
        slot_end      = (slot_q == SLOT_LAST);

        if (!bus.enable) begin
            state_d = ST_HUNT;
            slot_d  = '0;
            miss_d  = '0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    // The window already holds the tail, so the next bit is slot 0.
                    if (window_match) begin
                        state_d = ST_VERIFY;
                        slot_d  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (slot_end) begin
                        if (window_match) begin
                            state_d = ST_LOCKED;
                            emit    = 1'b1;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (slot_end) begin
                        if (window_match) begin
                            emit   = 1'b1;
                            miss_d = '0;
                        end else begin
                            err_count_d = sat_inc8(err_count_q);
                            if (miss_q == MISS_LAST) begin
                                state_d     = ST_HUNT;
                                sync_lost_d = 1'b1;
                                miss_d      = '0;
                            end else begin
                                miss_d = miss_q + 3'd1;
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (emit) begin
            snapshot_d    = frame_word;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge debug_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            slot_q        <= '0;
            miss_q        <= '0;
            snapshot_q    <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_lost_q   <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            miss_q        <= miss_d;
            snapshot_q    <= snapshot_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_lost_q   <= sync_lost_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.snapshot    = snapshot_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.sync_lost   = sync_lost_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_debug_frame_reader.sv
// Bench for debug_frame_reader: directed scenarios pinned by literal values,
// then randomized frames, all checked each cycle against a sample-history model.
module tb_debug_frame_reader;

    logic debug_clk;
    logic reset;

    debug_frame_reader_if bus ();

    debug_frame_reader dut (
        .debug_clk (debug_clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial debug_clk = 1'b0;
    always #5 debug_clk = ~debug_clk;

    localparam logic [3:0] GOOD_TAIL = 4'b1010;  // bit i is slot 12+i
    localparam logic [3:0] BAD_TAIL  = 4'b1111;

    int tests;
    int fails;
    bit chk_en;
    int sl_seen;

    // Model: last 16 samples (index 0 oldest) and alignment progress.
    bit          hist[$];
    int          mode;      // 0 hunting, 1 verifying, 2 locked
    int          pos;       // samples taken since alignment
    int          miss;
    logic [11:0] e_snap;
    logic        e_fv, e_lk, e_sl;
    logic [15:0] e_fc;
    int          e_ec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_window();
        hist.delete();
        repeat (16) hist.push_back(1'b0);
    endtask

    task automatic model_reset();
        model_clear_window();
        mode = 0; pos = 0; miss = 0;
        e_snap = '0; e_fv = 0; e_lk = 0; e_sl = 0; e_fc = '0; e_ec = 0;
    endtask

    task automatic model_step(input bit din, input bit en);
        bit tail;
        e_fv = 0;
        e_sl = 0;
        if (!en) begin
            model_clear_window();
            mode = 0; pos = 0; miss = 0;
            e_lk = 0;
            return;
        end
        hist.push_back(din);
        void'(hist.pop_front());
        tail = (hist[12] == 0) && (hist[13] == 1) && (hist[14] == 0) && (hist[15] == 1);
        if (mode == 0) begin
            if (tail) begin
                mode = 1;
                pos  = 0;
            end
        end else begin
            pos++;
            if (pos == 16) begin
                pos = 0;
                if (tail) begin
                    mode = 2;
                    miss = 0;
                    for (int i = 0; i < 12; i++) e_snap[i] = hist[i];
                    e_fv = 1;
                    e_fc = e_fc + 16'd1;
                end else if (mode == 1) begin
                    mode = 0;
                end else begin
                    if (e_ec < 255) e_ec++;
                    miss++;
                    if (miss == 3) begin
                        mode = 0;
                        miss = 0;
                        e_sl = 1;
                    end
                end
            end
        end
        e_lk = (mode == 2);
    endtask

    always @(negedge debug_clk) begin
        if (chk_en) begin
            check("snapshot", 32'(bus.snapshot), 32'(e_snap));
            check("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
            check("locked", 32'(bus.locked), 32'(e_lk));
            check("sync_lost", 32'(bus.sync_lost), 32'(e_sl));
            check("frame_count", 32'(bus.frame_count), 32'(e_fc));
            check("err_count", 32'(bus.err_count), 32'(e_ec));
            if (bus.sync_lost === 1'b1) sl_seen++;
        end
    end

    task automatic tick(input bit din, input bit en);
        bus.debug_in = din;
        bus.enable   = en;
        @(posedge debug_clk);
        model_step(din, en);
        @(negedge debug_clk);
    endtask

    task automatic send_frame(input logic [11:0] data, input logic [3:0] tail);
        for (int i = 0; i < 12; i++) tick(data[i], 1'b1);
        for (int i = 0; i < 4; i++) tick(tail[i], 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " snapshot"}, 32'(bus.snapshot), 32'd0);
        check({tag, " frame_valid"}, 32'(bus.frame_valid), 32'd0);
        check({tag, " locked"}, 32'(bus.locked), 32'd0);
        check({tag, " sync_lost"}, 32'(bus.sync_lost), 32'd0);
        check({tag, " frame_count"}, 32'(bus.frame_count), 32'd0);
        check({tag, " err_count"}, 32'(bus.err_count), 32'd0);
    endtask

    initial begin
        int sl0;
        int r;
        tests = 0; fails = 0; chk_en = 0; sl_seen = 0;
        reset = 1'b1;
        bus.debug_in = 1'b0;
        bus.enable   = 1'b0;
        model_reset();
        repeat (3) @(negedge debug_clk);
        check_all_zero("reset");
        reset  = 1'b0;
        chk_en = 1;

        // Clean acquisition: align on frame 1 tail, verify frame 2, emit 2 and 3.
        repeat (3) send_frame(12'h0F3, GOOD_TAIL);
        check("acq snapshot", 32'(bus.snapshot), 32'h0F3);
        check("acq frame_count", 32'(bus.frame_count), 32'd2);
        check("acq locked", 32'(bus.locked), 32'd1);
        check("acq frame_valid", 32'(bus.frame_valid), 32'd1);

        // Three bad tails while locked -> one sync_lost, snapshot held.
        sl0 = sl_seen;
        repeat (3) send_frame(12'h0F3, BAD_TAIL);
        tick(1'b0, 1'b1);
        check("loss sync_lost pulses", 32'(sl_seen - sl0), 32'd1);
        check("loss err_count", 32'(bus.err_count), 32'd3);
        check("loss locked", 32'(bus.locked), 32'd0);
        check("loss snapshot", 32'(bus.snapshot), 32'h0F3);
        check("loss frame_count", 32'(bus.frame_count), 32'd2);

        repeat (3) send_frame(12'h0F3, GOOD_TAIL);
        check("relock frame_count", 32'(bus.frame_count), 32'd4);
        check("relock locked", 32'(bus.locked), 32'd1);

        // Two misses then a good frame: stays locked, miss count cleared.
        send_frame(12'h123, BAD_TAIL);
        send_frame(12'h456, BAD_TAIL);
        send_frame(12'h3C6, GOOD_TAIL);
        check("2miss err_count", 32'(bus.err_count), 32'd5);
        check("2miss locked", 32'(bus.locked), 32'd1);
        check("2miss frame_count", 32'(bus.frame_count), 32'd5);
        check("2miss frame_valid", 32'(bus.frame_valid), 32'd1);
        check("2miss snapshot", 32'(bus.snapshot), 32'h3C6);

        // Async reset at slot 7 of a locked frame.
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all_zero("midreset");
        repeat (2) @(negedge debug_clk);
        reset = 1'b0;

        // Data bits 8..11 alias the tail; VERIFY must reject it.
        send_frame(12'hAFF, GOOD_TAIL);
        repeat (3) send_frame(12'h0F3, GOOD_TAIL);
        check("alias frame_count", 32'(bus.frame_count), 32'd2);
        check("alias err_count", 32'(bus.err_count), 32'd0);
        check("alias locked", 32'(bus.locked), 32'd1);
        check("alias snapshot", 32'(bus.snapshot), 32'h0F3);

        // Enable dropped mid-frame while locked.
        sl0 = sl_seen;
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        repeat (5) tick(1'b1, 1'b0);
        check("endrop locked", 32'(bus.locked), 32'd0);
        check("endrop frame_count", 32'(bus.frame_count), 32'd2);
        check("endrop frame_valid", 32'(bus.frame_valid), 32'd0);
        repeat (3) send_frame(12'h0F3, GOOD_TAIL);
        check("reenable frame_count", 32'(bus.frame_count), 32'd4);
        check("reenable locked", 32'(bus.locked), 32'd1);
        check("reenable no sync_lost", 32'(sl_seen - sl0), 32'd0);

        // Randomized traffic.
        repeat (250) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                send_frame(12'($urandom), GOOD_TAIL);
            end else if (r < 80) begin
                send_frame(12'($urandom), 4'($urandom));
            end else if (r < 92) begin
                repeat ($urandom_range(1, 20)) tick(1'($urandom), 1'b1);
            end else begin
                repeat ($urandom_range(1, 5)) tick(1'($urandom), 1'b0);
            end
        end
        repeat (4) tick(1'b0, 1'b1);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
